// File: rtl/power_sched_if.sv
// power_sched_if: ready/valid bus between the STFT output, the power sequencer
// and the Mel filterbank. The slave modport is the power_sched side; the master
// modport is the side that feeds bins in and takes power values out.
interface power_sched_if #(
    parameter int IW    = 18,
    parameter int SHIFT = 6,
    parameter int NBINS = 257
);
    localparam int OW = 2*IW+1-SHIFT;
    localparam int BW = $clog2(NBINS);

    logic signed [IW-1:0] real_il;
    logic signed [IW-1:0] imag_il;
    logic                 valid_il;
    logic                 ready_ol;
    logic [OW-1:0]        power_ol;
    logic                 valid_ol;
    logic                 ready_il;
    logic [BW-1:0]        bin_ol;
    logic                 last_ol;

    modport slave (
        input  real_il, imag_il, valid_il, ready_il,
        output ready_ol, power_ol, valid_ol, bin_ol, last_ol
    );

    modport master (
        output real_il, imag_il, valid_il, ready_il,
        input  ready_ol, power_ol, valid_ol, bin_ol, last_ol
    );
endinterface

// File: rtl/power_sched.sv
// power_sched: bin power (real^2 + imag^2) >> SHIFT computed with a single
// time-shared signed squarer. One bin takes three clocks: capture, square the
// real part, square-and-accumulate the imaginary part, then present the result
// with a ready/valid handshake.
// Optional feature: define POWER_SCHED_TLAST_EN to build the frame bin counter
// driving bin_ol/last_ol; without it both outputs are tied low.
module power_sched #(
    parameter int IW    = 18,
    parameter int SHIFT = 6,
    parameter int NBINS = 257
) (
    input  logic          clk,
    input  logic          rst_n,
    power_sched_if.slave  bus
);
    localparam int OW = 2*IW+1-SHIFT;
    localparam int BW = $clog2(NBINS);

    typedef enum logic [1:0] {IDLE, SQ_RE, SQ_IM, OUT} state_t;

    state_t               state_q, state_d;
    logic signed [IW-1:0] re_q, re_d;
    logic signed [IW-1:0] im_q, im_d;
    logic [2*IW:0]        acc_q, acc_d;
    logic                 valid_q, valid_d;

    logic signed [IW-1:0]   sq_op;
    logic signed [2*IW-1:0] sq_ext;
    logic signed [2*IW-1:0] sq_prod;
    logic [2*IW-1:0]        sq_res;

    // The one squarer: real part while in SQ_RE, imaginary part otherwise.
    // A square is never negative and at most 2^(2*IW-2), so the low 2*IW bits
    // of the signed product are exact.
    assign sq_op   = (state_q == SQ_RE) ? re_q : im_q;
    assign sq_ext  = (2*IW)'(sq_op);
    assign sq_prod = sq_ext * sq_ext;
    assign sq_res  = $unsigned(sq_prod);

    // Accept when idle, or when the held result leaves on this same edge.
    assign bus.ready_ol = (state_q == IDLE) | ((state_q == OUT) & bus.ready_il);

    // Dropping LSBs only; the 2*IW+1-bit accumulator already covers the worst case.
    assign bus.power_ol = acc_q[2*IW:SHIFT];
    assign bus.valid_ol = valid_q;

    // Next-state logic for the sequencer, operands and accumulator.
    always_comb begin
        state_d = state_q;
        re_d    = re_q;
        im_d    = im_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_il) begin
                    re_d    = bus.real_il;
                    im_d    = bus.imag_il;
                    state_d = SQ_RE;
                end
            end
            SQ_RE: begin
                acc_d   = {1'b0, sq_res};
                state_d = SQ_IM;
            end
            SQ_IM: begin
                acc_d   = acc_q + {1'b0, sq_res};
                state_d = OUT;
            end
            OUT: begin
                if (bus.ready_il) begin
                    if (bus.valid_il) begin
                        re_d    = bus.real_il;
                        im_d    = bus.imag_il;
                        state_d = SQ_RE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == OUT);
    end

    // Sequencer state and datapath registers; reset aborts any bin in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            re_q    <= '0;
            im_q    <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            im_q    <= im_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
        end
    end

`ifdef POWER_SCHED_TLAST_EN
    logic [BW-1:0] bin_q, bin_d;

    // Frame position advances on every output handshake and wraps per frame.
    always_comb begin
        bin_d = bin_q;
        if (valid_q && bus.ready_il) begin
            if (bin_q == BW'(NBINS-1)) bin_d = '0;
            else                       bin_d = bin_q + BW'(1);
        end
    end

    // Frame bin counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bin_q <= '0;
        else        bin_q <= bin_d;
    end

    assign bus.bin_ol  = bin_q;
    assign bus.last_ol = valid_q & (bin_q == BW'(NBINS-1));
`else
    assign bus.bin_ol  = '0;
    assign bus.last_ol = 1'b0;
`endif

endmodule

// File: tb/tb_power_sched.sv
// tb_power_sched: directed bench for power_sched with hand-computed powers.
// Bin/last expectations follow POWER_SCHED_TLAST_EN the same way as the design.
module tb_power_sched;
    localparam int IW    = 18;
    localparam int SHIFT = 6;
    localparam int NBINS = 257;
    localparam int OW    = 2*IW+1-SHIFT;
    localparam int BW    = $clog2(NBINS);

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   out_count;

    power_sched_if #(.IW(IW), .SHIFT(SHIFT), .NBINS(NBINS)) bus ();

    power_sched #(.IW(IW), .SHIFT(SHIFT), .NBINS(NBINS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] exp_bin();
`ifdef POWER_SCHED_TLAST_EN
        return BW'(out_count % NBINS);
`else
        return '0;
`endif
    endfunction

    function automatic logic exp_last();
`ifdef POWER_SCHED_TLAST_EN
        return (out_count % NBINS) == NBINS-1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int re, input int im);
        bus.real_il  = IW'(re);
        bus.imag_il  = IW'(im);
        bus.valid_il = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.ready_il = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.real_il  = IW'($urandom);
            bus.imag_il  = IW'($urandom);
            bus.valid_il = 1'($urandom);
            bus.ready_il = 1'($urandom);
            tick();
        end
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", bus.valid_ol); end
        n_cmp++; if (bus.power_ol !== '0) begin n_bad++; $display("FAIL reset_power: got %0d want 0", bus.power_ol); end
        n_cmp++; if (bus.bin_ol !== '0) begin n_bad++; $display("FAIL reset_bin: got %0d want 0", bus.bin_ol); end
        n_cmp++; if (bus.last_ol !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %0b want 0", bus.last_ol); end
        bus.valid_il = 1'b0;
        bus.ready_il = 1'b1;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.ready_ol !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", bus.ready_ol); end
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL reset_valid_after: got %0b want 0", bus.valid_ol); end
        out_count = 0;
    endtask

    task automatic test_single();
        bus.ready_il = 1'b1;
        drive(80, -48);
        tick();
        bus.valid_il = 1'b0;
        bus.real_il  = IW'(7);
        bus.imag_il  = IW'(7);
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL single_valid_e0: got %0b want 0", bus.valid_ol); end
        n_cmp++; if (bus.ready_ol !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %0b want 0", bus.ready_ol); end
        tick();
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL single_valid_e1: got %0b want 0", bus.valid_ol); end
        tick();
        n_cmp++; if (bus.valid_ol !== 1'b1) begin n_bad++; $display("FAIL single_valid_e2: got %0b want 1", bus.valid_ol); end
        n_cmp++; if (bus.power_ol !== OW'(136)) begin n_bad++; $display("FAIL single_power: got %0d want 136", bus.power_ol); end
        n_cmp++; if (bus.bin_ol !== exp_bin()) begin n_bad++; $display("FAIL single_bin: got %0d want %0d", bus.bin_ol, exp_bin()); end
        n_cmp++; if (bus.last_ol !== exp_last()) begin n_bad++; $display("FAIL single_last: got %0b want %0b", bus.last_ol, exp_last()); end
        tick();
        out_count++;
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL single_idle_valid: got %0b want 0", bus.valid_ol); end
        n_cmp++; if (bus.ready_ol !== 1'b1) begin n_bad++; $display("FAIL single_idle_ready: got %0b want 1", bus.ready_ol); end
    endtask

    task automatic test_extreme();
        bus.ready_il = 1'b1;
        drive(-131072, -131072);
        tick();
        bus.valid_il = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.valid_ol !== 1'b1) begin n_bad++; $display("FAIL extreme_valid: got %0b want 1", bus.valid_ol); end
        n_cmp++; if (bus.power_ol !== OW'(536870912)) begin n_bad++; $display("FAIL extreme_power: got %0d want 536870912", bus.power_ol); end
        n_cmp++; if (bus.power_ol[OW-1] !== 1'b0) begin n_bad++; $display("FAIL extreme_msb: got %0b want 0", bus.power_ol[OW-1]); end
        tick();
        out_count++;
    endtask

    task automatic test_backpressure();
        bus.ready_il = 1'b0;
        drive(100, 60);
        tick();
        drive(-200, 10);
        tick();
        tick();
        n_cmp++; if (bus.valid_ol !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %0b want 1", bus.valid_ol); end
        n_cmp++; if (bus.power_ol !== OW'(212)) begin n_bad++; $display("FAIL bp_power: got %0d want 212", bus.power_ol); end
        for (int k = 0; k < 5; k++) begin
            drive(5000 + k, -3000 - k);
            #1;
            n_cmp++; if (bus.ready_ol !== 1'b0) begin n_bad++; $display("FAIL bp_ready_stall: got %0b want 0", bus.ready_ol); end
            tick();
            n_cmp++; if (bus.valid_ol !== 1'b1) begin n_bad++; $display("FAIL bp_valid_stall: got %0b want 1", bus.valid_ol); end
            n_cmp++; if (bus.power_ol !== OW'(212)) begin n_bad++; $display("FAIL bp_power_stall: got %0d want 212", bus.power_ol); end
            n_cmp++; if (bus.bin_ol !== exp_bin()) begin n_bad++; $display("FAIL bp_bin_stall: got %0d want %0d", bus.bin_ol, exp_bin()); end
        end
        drive(-200, 10);
        bus.ready_il = 1'b1;
        #1;
        n_cmp++; if (bus.ready_ol !== 1'b1) begin n_bad++; $display("FAIL bp_ready_release: got %0b want 1", bus.ready_ol); end
        tick();
        out_count++;
        bus.valid_il = 1'b0;
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL bp_valid_after: got %0b want 0", bus.valid_ol); end
        tick();
        tick();
        n_cmp++; if (bus.valid_ol !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid: got %0b want 1", bus.valid_ol); end
        n_cmp++; if (bus.power_ol !== OW'(626)) begin n_bad++; $display("FAIL bp_next_power: got %0d want 626", bus.power_ol); end
        n_cmp++; if (bus.bin_ol !== exp_bin()) begin n_bad++; $display("FAIL bp_next_bin: got %0d want %0d", bus.bin_ol, exp_bin()); end
        tick();
        out_count++;
    endtask

    task automatic test_stream();
        logic [OW-1:0] ep;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_count = 0;
        bus.ready_il = 1'b1;
        drive(0, 0);
        for (int i = 0; i < 514; i++) begin
            tick();
            drive(i + 1, 0);
            tick();
            n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL stream_gap i=%0d: got %0b want 0", i, bus.valid_ol); end
            tick();
            if (i == 513) bus.valid_il = 1'b0;
            ep = OW'((i * i) >> 6);
            n_cmp++; if (bus.valid_ol !== 1'b1) begin n_bad++; $display("FAIL stream_valid i=%0d: got %0b want 1", i, bus.valid_ol); end
            n_cmp++; if (bus.power_ol !== ep) begin n_bad++; $display("FAIL stream_power i=%0d: got %0d want %0d", i, bus.power_ol, ep); end
            n_cmp++; if (bus.bin_ol !== exp_bin()) begin n_bad++; $display("FAIL stream_bin i=%0d: got %0d want %0d", i, bus.bin_ol, exp_bin()); end
            n_cmp++; if (bus.last_ol !== exp_last()) begin n_bad++; $display("FAIL stream_last i=%0d: got %0b want %0b", i, bus.last_ol, exp_last()); end
            n_cmp++; if (bus.ready_ol !== 1'b1) begin n_bad++; $display("FAIL stream_ready i=%0d: got %0b want 1", i, bus.ready_ol); end
            out_count++;
        end
        tick();
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL stream_end_valid: got %0b want 0", bus.valid_ol); end
    endtask

    task automatic test_async_reset();
        // One completed bin so the counter is off zero (when built).
        bus.ready_il = 1'b1;
        drive(10, 0);
        tick();
        bus.valid_il = 1'b0;
        tick(); tick(); tick();
        out_count++;
        // Reset while a result is held under backpressure.
        bus.ready_il = 1'b0;
        drive(80, -48);
        tick();
        bus.valid_il = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.valid_ol !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid: got %0b want 1", bus.valid_ol); end
        n_cmp++; if (bus.bin_ol !== exp_bin()) begin n_bad++; $display("FAIL areset_pre_bin: got %0d want %0d", bus.bin_ol, exp_bin()); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid: got %0b want 0", bus.valid_ol); end
        n_cmp++; if (bus.bin_ol !== '0) begin n_bad++; $display("FAIL areset_out_bin: got %0d want 0", bus.bin_ol); end
        n_cmp++; if (bus.power_ol !== '0) begin n_bad++; $display("FAIL areset_out_power: got %0d want 0", bus.power_ol); end
        out_count = 0;
        tick();
        rst_n = 1'b1;
        // Another completed bin, then reset in SQ_IM.
        bus.ready_il = 1'b1;
        drive(10, 0);
        tick();
        bus.valid_il = 1'b0;
        tick(); tick(); tick();
        out_count++;
        drive(1000, 1000);
        tick();
        bus.valid_il = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL areset_sqim_valid: got %0b want 0", bus.valid_ol); end
        n_cmp++; if (bus.bin_ol !== '0) begin n_bad++; $display("FAIL areset_sqim_bin: got %0d want 0", bus.bin_ol); end
        n_cmp++; if (bus.last_ol !== 1'b0) begin n_bad++; $display("FAIL areset_sqim_last: got %0b want 0", bus.last_ol); end
        out_count = 0;
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL areset_no_partial: got %0b want 0", bus.valid_ol); end
        // First sample after reset.
        drive(80, -48);
        tick();
        bus.valid_il = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.valid_ol !== 1'b1) begin n_bad++; $display("FAIL areset_post_valid: got %0b want 1", bus.valid_ol); end
        n_cmp++; if (bus.power_ol !== OW'(136)) begin n_bad++; $display("FAIL areset_post_power: got %0d want 136", bus.power_ol); end
        n_cmp++; if (bus.bin_ol !== '0) begin n_bad++; $display("FAIL areset_post_bin: got %0d want 0", bus.bin_ol); end
        tick();
        out_count++;
        n_cmp++; if (bus.valid_ol !== 1'b0) begin n_bad++; $display("FAIL areset_post_done: got %0b want 0", bus.valid_ol); end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        out_count    = 0;
        rst_n        = 1'b0;
        bus.real_il  = '0;
        bus.imag_il  = '0;
        bus.valid_il = 1'b0;
        bus.ready_il = 1'b0;
        test_reset();
        test_single();
        test_extreme();
        test_backpressure();
        test_stream();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/power_sched.md
# power_sched

Sequencer that time-shares one signed IW-bit squarer between the real and imaginary parts of each STFT bin. Computes power = real² + imag², scales it by dropping SHIFT LSBs, and delivers it downstream with a ready/valid handshake. Sits between the STFT output and the Mel filterbank. Replaces the two-squarer power stage wherever area matters more than throughput; one bin every 3 cycles is sufficient at the audio frame rate.

## Interface
- IW, 18: signed input width of real_il and imag_il.
- SHIFT, 6: LSBs dropped from the 2*IW+1-bit sum.
- NBINS, 257: bins per STFT frame, used by the bin counter.
- OW, 2*IW+1-SHIFT (derived, localparam): power_ol width.
- BW, $clog2(NBINS) (derived, localparam): bin_ol width.
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- real_il  in  IW  signed real part of the bin.
- imag_il  in  IW  signed imaginary part of the bin.
- valid_il  in  1  input sample valid.
- ready_ol  out  1  block can accept a sample.
- power_ol  out  OW  scaled power.
- valid_ol  out  1  power_ol valid.
- ready_il  in  1  downstream accepts.
- bin_ol  out  BW  bin index of power_ol.
- last_ol  out  1  power_ol is the final bin of the frame.

## Operation
- Contains exactly one combinational signed squarer. Its operand is muxed from re_q or im_q by state. Its result is 2*IW bits, unsigned.
- Registers:
  - re_q, im_q: captured operands.
  - acc: 2*IW+1 bits.
  - state.
  - bin_q: frame bin counter.
- FSM states: IDLE, SQ_RE, SQ_IM, OUT.
  - IDLE: ready_ol=1. On valid_il, capture real_il/imag_il into re_q/im_q and go to SQ_RE.
  - SQ_RE: acc <= zero-extended sq(re_q). Go to SQ_IM.
  - SQ_IM: acc <= acc + sq(im_q). Go to OUT.
  - OUT: valid_ol=1.
    - If ready_il=0, hold all state.
    - If ready_il=1 and valid_il=1, capture the new sample and go to SQ_RE (no IDLE bubble).
    - If ready_il=1 and valid_il=0, go to IDLE.
- ready_ol = (state==IDLE) | (state==OUT & ready_il). This path is combinational from ready_il.
- power_ol = acc[2*IW:SHIFT]. It is driven directly from the register and is never truncated at the MSB.
- Worst case: two operands of -2^(IW-1) give 2^(2*IW-1), which fits without overflow.
- Input input handshake: a sample transfers on an edge where valid_il & ready_ol. Output handshake: on an edge where valid_ol & ready_il.
- Output stall: while valid_ol=1 and ready_il=0, power_ol, bin_ol and last_ol are held stable. No input is accepted.
- Reset values (async, on rst_n low):
  - state=IDLE.
  - acc, re_q, im_q, bin_q = 0.
  - valid_ol=0, power_ol=0, bin_ol=0, last_ol=0.
  - ready_ol=1 once reset has deasserted.

## Timing
- Latency: input handshake at edge E0 → SQ_RE after E0, SQ_IM after E1, OUT after E2. valid_ol is high in the cycle following E2, i.e. 3 clocks after acceptance.
- Throughput: with valid_il and ready_il held high, one sample is accepted every 3 clocks and one output is produced every 3 clocks.
- valid_il may drop at any time without consequence. Captured operands are unaffected by later input changes.
- Reset asserted mid-operation aborts the sample in flight immediately. No partial output is ever emitted.

## Configuration
- POWER_SCHED_TLAST_EN defined:
  - bin_q increments on each output handshake and wraps from NBINS-1 to 0.
  - bin_ol = bin_q.
  - last_ol = valid_ol & (bin_q == NBINS-1).
- POWER_SCHED_TLAST_EN undefined: no counter is built, and bin_ol and last_ol are tied to 0.

## Test plan
- Reset: hold rst_n=0 with random inputs → valid_ol=0, power_ol=0, bin_ol=0, last_ol=0; after release ready_ol=1.
- Single sample: real=80, imag=-48, ready_il=1 → valid_ol is high exactly 3 clocks after accept with power_ol=136 ((6400+2304)>>6). Then back to IDLE.
- Extreme operands: real=imag=-131072 → power_ol=536870912 (2^35>>6). No wrap, MSB of acc=0.
- Backpressure: ready_il=0 for 5 cycles while in OUT, with valid_il=1 → power_ol stable, ready_ol=0, no capture. When ready_il rises, output transfers and the new sample is captured on the same edge.
- Streaming frame (macro on): 514 samples back-to-back with ready_il=1 and real=i, imag=0 →
  - outputs appear every 3 clocks with power_ol=(i*i)>>6;
  - bin_ol counts 0..256;
  - last_ol is high only at bin 256;
  - the bin count wraps to 0 for the second frame.
- Async reset mid-op: assert rst_n in SQ_IM → valid_ol drops without waiting for a clock edge and bin_ol=0. After release, the first new sample yields the correct power with bin_ol=0.
